k_wr_full_sync: RTL and testbench

- Write-domain status stage of the async FIFO. Sits directly downstream of the write-side dual gray counter and consumes its registered gray pointer.
- Synchronises the read-domain gray pointer into clk.
- Produces full, ready (fed back to the counter's ready input), almost-full and write-side fill level.
- Pointers carry one wrap bit, so FIFO depth = 2^(DATA_SIZE-1).

---
 rtl/k_wr_full_sync.sv | 98 +++++++++
 tb/tb_k_wr_full_sync.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/k_wr_full_sync.sv
// Write-domain FIFO status: read-pointer synchroniser, full/ready, almost-full
// and registered fill level. Ports: clk, rst_n, rptr_gray, wptr_gray, inc,
// full, ready, afull, wlevel, rptr_sync; ovf_err with K_WR_OVF_DET_EN defined.
module k_wr_full_sync #(
  parameter int DATA_SIZE    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] rptr_gray,
  input  logic [DATA_SIZE-1:0] wptr_gray,
  input  logic                 inc,
  output logic                 full,
  output logic                 ready,
  output logic                 afull,
  output logic [DATA_SIZE-1:0] wlevel,
`ifdef K_WR_OVF_DET_EN
  output logic                 ovf_err,
`endif
  output logic [DATA_SIZE-1:0] rptr_sync
);

  localparam int N = DATA_SIZE;

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] wbin;
  logic [N-1:0] rbin;
  logic [N-1:0] lvl_nxt;

  function automatic logic [N-1:0] g2b(
    input logic [N-1:0] g
  );
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Plain flop chain, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rptr_sync = sync_q[SYNC_STAGES-1];

  // Full when write pointer is one lap ahead: top two gray bits inverted.
  assign full  = (wptr_gray ==
                  {~rptr_sync[N-1:N-2], rptr_sync[N-3:0]});
  assign ready = ~full;

  assign wbin    = g2b(wptr_gray);
  assign rbin    = g2b(rptr_sync);
  assign lvl_nxt = wbin - rbin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wlevel <= '0;
      afull  <= 1'b0;
    end else begin
      wlevel <= lvl_nxt;
      afull  <= (lvl_nxt >= N'(AFULL_THRESH));
    end
  end

`ifdef K_WR_OVF_DET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (inc && full) begin
      ovf_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && inc && full) begin
      $display("WARNING: %m write attempted while full at %0t", $time);
    end
  end
`endif
`else
  // Writes while full are dropped by the counter's inc&&ready gating.
  logic unused_inc;
  assign unused_inc = inc;
`endif

endmodule

// File: tb/tb_k_wr_full_sync.sv
// Self-checking bench for k_wr_full_sync (DATA_SIZE=4, depth 8).
// Directed vector table plus hand-written multi-cycle sequences.
module tb_k_wr_full_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] rptr_gray;
  logic [3:0] wptr_gray;
  logic       inc;
  logic       full;
  logic       ready;
  logic       afull;
  logic [3:0] wlevel;
  logic [3:0] rptr_sync;
`ifdef K_WR_OVF_DET_EN
  logic       ovf_err;
`endif

  int n_chk;
  int n_fail;

  k_wr_full_sync #(
    .DATA_SIZE(4),
    .SYNC_STAGES(2),
    .AFULL_THRESH(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rptr_gray(rptr_gray),
    .wptr_gray(wptr_gray),
    .inc(inc),
    .full(full),
    .ready(ready),
    .afull(afull),
    .wlevel(wlevel),
`ifdef K_WR_OVF_DET_EN
    .ovf_err(ovf_err),
`endif
    .rptr_sync(rptr_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   wb;
    int   rb;
    logic ex_full;
    int   ex_lvl;
    logic ex_afull;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [3:0] gray(input int b);
    logic [3:0] t;
    t = 4'(b);
    return t ^ (t >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    inc    = 1'b0;
    rptr_gray = 4'b0000;
    wptr_gray = 4'b0000;

    vecs[0] = '{0,  0,  1'b0, 0, 1'b0};
    vecs[1] = '{3,  0,  1'b0, 3, 1'b0};
    vecs[2] = '{6,  0,  1'b0, 6, 1'b1};
    vecs[3] = '{8,  0,  1'b1, 8, 1'b1};
    vecs[4] = '{8,  1,  1'b0, 7, 1'b1};
    vecs[5] = '{13, 7,  1'b0, 6, 1'b1};
    vecs[6] = '{15, 7,  1'b1, 8, 1'b1};
    vecs[7] = '{2,  12, 1'b0, 6, 1'b1};
    vecs[8] = '{4,  12, 1'b1, 8, 1'b1};
    vecs[9] = '{5,  0,  1'b0, 5, 1'b0};

    // In reset
    #3;
    chk("rst_full", full, 0);
    chk("rst_ready", ready, 1);
    chk("rst_afull", afull, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_rsync", rptr_sync, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rel_full", full, 0);
    chk("rel_ready", ready, 1);
    chk("rel_wlevel", wlevel, 0);

    // Eight consecutive writes, read idle
    for (int k = 1; k <= 8; k++) begin
      wptr_gray = gray(k);
      #1;
      chk($sformatf("wr%0d_full", k), full, (k == 8) ? 1 : 0);
      chk($sformatf("wr%0d_ready", k), ready, (k == 8) ? 0 : 1);
      chk($sformatf("wr%0d_lvl_old", k), wlevel, k - 1);
      step();
      chk($sformatf("wr%0d_lvl", k), wlevel, k);
      chk($sformatf("wr%0d_afull", k), afull, (k >= 6) ? 1 : 0);
    end

`ifdef K_WR_OVF_DET_EN
    chk("ovf_pre", ovf_err, 0);
    inc = 1'b1;
    step();
    inc = 1'b0;
    chk("ovf_set", ovf_err, 1);
`endif

    // Read frees one entry: full drops after two sync edges
    rptr_gray = gray(1);
    step();
    chk("rd_e1_full", full, 1);
    chk("rd_e1_rsync", rptr_sync, 0);
    step();
    chk("rd_e2_full", full, 0);
    chk("rd_e2_rsync", rptr_sync, 1);
    chk("rd_e2_lvl", wlevel, 8);
    step();
    chk("rd_e3_lvl", wlevel, 7);
    chk("rd_e3_afull", afull, 1);

`ifdef K_WR_OVF_DET_EN
    chk("ovf_sticky", ovf_err, 1);
`endif

    // Table-driven steady-state vectors
    foreach (vecs[i]) begin
      wptr_gray = gray(vecs[i].wb);
      rptr_gray = gray(vecs[i].rb);
      repeat (3) step();
      chk($sformatf("v%0d_full", i), full, vecs[i].ex_full);
      chk($sformatf("v%0d_ready", i), ready, !vecs[i].ex_full);
      chk($sformatf("v%0d_lvl", i), wlevel, vecs[i].ex_lvl);
      chk($sformatf("v%0d_afull", i), afull, vecs[i].ex_afull);
      chk($sformatf("v%0d_rsync", i), rptr_sync, gray(vecs[i].rb));
    end

    // Simultaneous advance at level 5 (state: w=5, r=0)
    rptr_gray = gray(1);
    step();
    step();
    wptr_gray = gray(6);
    chk("sim_e2_lvl", wlevel, 5);
    step();
    chk("sim_e3_lvl", wlevel, 5);
    chk("sim_e3_afull", afull, 0);
    chk("sim_e3_full", full, 0);

    // Mid-operation reset with counter and read side reset together
    wptr_gray = gray(9);
    repeat (3) step();
    chk("pre_rst_full", full, 1);
    chk("pre_rst_lvl", wlevel, 8);
    #2;
    rst_n = 1'b0;
    wptr_gray = 4'b0000;
    rptr_gray = 4'b0000;
    #1;
    chk("mid_rst_full", full, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_lvl", wlevel, 0);
    chk("mid_rst_afull", afull, 0);
    chk("mid_rst_rsync", rptr_sync, 0);
`ifdef K_WR_OVF_DET_EN
    chk("ovf_clear", ovf_err, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_lvl", wlevel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
